// File: rtl/arm_pipelined_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : arm_pipelined_fetch_unit
// Description : Pipelined instruction fetch front end. Issues word-aligned
//               fetch requests under a credit limit, buffers in-order memory
//               responses with their addresses, presents them to decode, and
//               flushes/drains outstanding requests on an execute redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_pipelined_fetch_unit #(
  parameter int unsigned         BusWidth    = 32,
  parameter int unsigned         QueueDepth  = 2,
  parameter logic [BusWidth-1:0] ResetVector = BusWidth'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                IMemReq,
  output logic [BusWidth-1:0] IMemAddr,
  input  logic                IMemGnt,
  input  logic                IMemRValid,
  input  logic [BusWidth-1:0] IMemRData,
  input  logic                StallD,
  input  logic                RedirectE,
  input  logic [BusWidth-1:0] BranchTargetE,
  output logic [BusWidth-1:0] InstrD,
  output logic [BusWidth-1:0] PCD,
  output logic [BusWidth-1:0] PCPlus8D,
  output logic                ValidD
);

  localparam int unsigned      CNT_W    = $clog2(QueueDepth + 1);
  localparam int unsigned      PTR_W    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(QueueDepth);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QueueDepth - 1);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q;
  logic [BusWidth-1:0] pc_q;
  logic [BusWidth-1:0] rsp_pc_q;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    stale_q, stale_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [BusWidth-1:0] instr_q [QueueDepth];
  logic [BusWidth-1:0] addr_q  [QueueDepth];

  logic                rsp_stale;
  logic                rsp_live;
  logic                deq;
  logic                enq;
  logic                grant;
  logic [CNT_W:0]      occupancy;
  logic [BusWidth-1:0] target_aligned;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign target_aligned = BranchTargetE & ~BusWidth'(3);

  // Response classification, credit check and next-state counter values.
  // Stale responses are always older than live ones, so while any stale
  // response is owed the returning word belongs to it.
  always_comb begin
    rsp_stale  = IMemRValid && (stale_q != '0);
    rsp_live   = IMemRValid && (stale_q == '0) && (inflight_q != '0);
    deq        = (count_q != '0) && !StallD && !RedirectE;
    enq        = rsp_live && !RedirectE;
    // A slot freed by this cycle's dequeue is already usable as a credit.
    occupancy  = {1'b0, inflight_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, deq};
    IMemReq    = reset_n && (state_q == FETCH) && !RedirectE && (occupancy < DEPTH_C);
    grant      = IMemReq && IMemGnt;
    if (RedirectE) begin
      // Everything still owed becomes stale, minus a word returning right now.
      stale_d    = stale_q + inflight_q - CNT_W'(rsp_stale || rsp_live);
      inflight_d = '0;
    end else begin
      stale_d    = stale_q - CNT_W'(rsp_stale);
      inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(rsp_live);
    end
    count_d    = RedirectE ? '0 : count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  assign IMemAddr = pc_q;
  assign ValidD   = (count_q != '0);
  assign InstrD   = instr_q[head_q];
  assign PCD      = addr_q[head_q];
  assign PCPlus8D = PCD + BusWidth'(8);

  // Fetch PC: redirect overrides, otherwise advance one word per accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= ResetVector;
    end else if (RedirectE) begin
      pc_q <= target_aligned;
    end else if (grant) begin
      pc_q <= pc_q + BusWidth'(4);
    end
  end

  // Fetch/drain control with outstanding-request bookkeeping and the address
  // of the oldest live outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      inflight_q <= '0;
      stale_q    <= '0;
      rsp_pc_q   <= ResetVector;
    end else begin
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      if (RedirectE) begin
        rsp_pc_q <= target_aligned;
      end else if (rsp_live) begin
        rsp_pc_q <= rsp_pc_q + BusWidth'(4);
      end
      if (state_q == FETCH) begin
        if (RedirectE && (stale_d != '0)) begin
          state_q <= DRAIN;
        end
      end else begin
        if (stale_d == '0) begin
          state_q <= FETCH;
        end
      end
    end
  end

  // In-order instruction buffer feeding decode; a redirect empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(QueueDepth); i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      if (RedirectE) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (deq) begin
          head_q <= next_ptr(head_q);
        end
        if (enq) begin
          instr_q[tail_q] <= IMemRData;
          addr_q[tail_q]  <= rsp_pc_q;
          tail_q          <= next_ptr(tail_q);
        end
      end
    end
  end

endmodule
`default_nettype wire
